urna_multi: RTL and testbench
=============================

Name: urna_multi

Overview:
- Parametrised electronic ballot box: N candidates, configurable code width and tally width.
- Voter keys a code, may correct it, then confirms; the box tallies per-candidate and null votes.
- On finish, the box closes and runs a sequential winner scan that reports winner index and tie.
- Successor to the fixed 2-candidate urn; sits between the keypad/debounce front end and the result display.

Parameters:
NUM_CAND, 4, number of candidates; legal codes 1..NUM_CAND (2..15)
CODE_W, 4, width of keyed code; must satisfy 2^CODE_W > NUM_CAND
CNT_W, 8, width of every tally counter
IDX_W, 4, width of winner index output; must hold NUM_CAND

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
digit  input  CODE_W  keyed candidate code
digit_load  input  1  level; latches digit into code register while high in OPEN/ENTERED
swap  input  1  level; discards latched code (correction), returns to OPEN
valid  input  1  confirm; acts on 0->1 transition only
finish  input  1  closes voting, level, sampled each cycle
vote_status  output  1  one-cycle pulse: vote recorded
tally  output  NUM_CAND*CNT_W  packed counters, candidate k at bits [k*CNT_W +: CNT_W] (k=0 is code 1)
null_count  output  CNT_W  votes with code 0 or >NUM_CAND
total_votes  output  CNT_W+IDX_W  all recorded votes, never saturates within range
overflow  output  1  sticky: any tally/null counter saturated
closed  output  1  high in SCAN and DONE
results_valid  output  1  high in DONE
winner  output  IDX_W  candidate code (1..NUM_CAND) with highest tally; 0 if all tallies zero
tie  output  1  highest tally shared by >=2 candidates

Behaviour:
- Reset (clk edge with rst_n=0): state OPEN, all counters 0, code register 0, valid history 0, all outputs 0. Reset applies in any state, including mid-scan.
- valid edge: valid_rise = valid & ~valid_q; valid_q registered every cycle (also in CLOSED, so held-high valid never re-fires).
- States: OPEN, ENTERED, SCAN, DONE.
- OPEN: digit_load -> latch digit, go ENTERED. valid_rise ignored (no vote without code).
- ENTERED: digit_load re-latches (last value wins). swap -> clear code, OPEN (swap beats valid and digit_load same cycle). valid_rise -> record vote, vote_status=1 next cycle for exactly one cycle, clear code, OPEN.
- Recording: code in 1..NUM_CAND increments tally[code-1]; else increments null_count. total_votes increments always. Counter at 2^CNT_W-1 holds value and sets overflow.
- finish high in OPEN or ENTERED -> SCAN next cycle; finish has priority: a valid_rise in the same cycle is discarded, no vote_status. Latched code cleared.
- SCAN: one candidate per cycle, index 0..NUM_CAND-1; running max, winner, tie. Greater tally -> new winner, tie=0; equal nonzero tally -> tie=1. Exactly NUM_CAND cycles, then DONE.
- DONE: results_valid=1, outputs frozen; all inputs except rst_n ignored. finish deassertion does not reopen.
- winner/tie update only on entry to DONE; 0 before.
- Latency: vote_status and counter update visible 1 cycle after valid_rise edge; results_valid asserts NUM_CAND+1 cycles after finish sampled.

Test Plan:
- Reset then keys 3,3,4 (NUM_CAND=4), each confirmed with valid held high between votes only after a low cycle -> tally[2]=2, tally[3]=1, total_votes=3, three single-cycle vote_status pulses.
- valid held high continuously after first confirm, second code loaded -> second vote not counted until valid drops and rises; total_votes stays 1 meanwhile.
- Load 2, swap, load 0, confirm -> null_count=1, tally[1]=0; code 6 confirmed -> null_count=2.
- CNT_W=2, five votes for code 1 -> tally[0]=3, overflow=1, total_votes=5.
- Votes 1,1,2,2,3 then finish -> results_valid after 5 cycles, winner=1, tie=1; votes 2,2,1 -> winner=2, tie=0; no votes -> winner=0, tie=0.
- finish and valid_rise in same cycle -> vote dropped, no vote_status; rst_n low during SCAN -> next cycle OPEN, all counters 0, closed=0.

Source files
------------

// File: rtl/urna_multi.sv
// -----------------------------------------------------------------------------
// urna_multi -- parametrised electronic ballot box.
//
// A voter keys a candidate code (digit + digit_load), may discard it (swap),
// and confirms on a rising edge of valid. Each confirmed vote goes either to a
// per-candidate tally (codes 1..NUM_CAND) or to the null counter. A high
// finish closes the box. The box then scans the tallies one candidate per
// cycle, and after NUM_CAND cycles it reports the winner and any tie.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   digit         keyed candidate code
//   digit_load    latch digit into the code register (OPEN/ENTERED)
//   swap          discard the latched code, back to OPEN
//   valid         confirm; only its 0->1 transition counts
//   finish        close voting (level, sampled every cycle)
//   vote_status   one-cycle pulse after each recorded vote
//   tally         packed counters, candidate k at [k*CNT_W +: CNT_W]
//   null_count    votes with code 0 or > NUM_CAND
//   total_votes   all recorded votes
//   overflow      sticky: a tally or null counter was hit while saturated
//   closed        high while scanning and when done
//   results_valid high when done
//   winner        code of the highest tally (0 if all tallies are zero)
//   tie           highest tally shared by two or more candidates
// -----------------------------------------------------------------------------
module urna_multi #(
   parameter int NUM_CAND = 4,
   parameter int CODE_W   = 4,
   parameter int CNT_W    = 8,
   parameter int IDX_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CODE_W-1:0]         digit,
   input  logic                      digit_load,
   input  logic                      swap,
   input  logic                      valid,
   input  logic                      finish,
   output logic                      vote_status,
   output logic [NUM_CAND*CNT_W-1:0] tally,
   output logic [CNT_W-1:0]          null_count,
   output logic [CNT_W+IDX_W-1:0]    total_votes,
   output logic                      overflow,
   output logic                      closed,
   output logic                      results_valid,
   output logic [IDX_W-1:0]          winner,
   output logic                      tie
);

   typedef enum logic [1:0] {ST_OPEN, ST_ENTERED, ST_SCAN, ST_DONE} state_t;

   state_t                   state_reg, state_next;
   logic [CODE_W-1:0]        code_reg;
   logic                     valid_q_reg;
   logic                     vote_status_reg;
   logic [CNT_W-1:0]         null_reg;
   logic [CNT_W+IDX_W-1:0]   total_reg;
   logic                     overflow_reg;
   logic [IDX_W-1:0]         scan_idx_reg;
   logic [CNT_W-1:0]         max_reg;
   logic [IDX_W-1:0]         best_reg;
   logic                     tie_run_reg;
   logic [IDX_W-1:0]         winner_reg;
   logic                     tie_reg;

   logic                     valid_rise;
   logic                     record;
   logic                     code_hit;
   logic                     null_inc;
   logic                     null_sat;
   logic                     last_scan;
   logic [NUM_CAND*CNT_W-1:0] tally_flat;
   logic [NUM_CAND-1:0]      cand_sat;
   logic [CNT_W-1:0]         scan_val;
   logic [CNT_W-1:0]         max_next;
   logic [IDX_W-1:0]         best_next;
   logic                     tie_next;

   assign valid_rise = valid & ~valid_q_reg;
   // finish and swap both take priority over a confirm in the same cycle
   assign record     = (state_reg == ST_ENTERED) & ~finish & ~swap & valid_rise;
   assign code_hit   = (code_reg != '0) && (code_reg <= CODE_W'(NUM_CAND));
   assign null_inc   = record & ~code_hit;
   assign null_sat   = null_inc & (null_reg == '1);
   assign last_scan  = (state_reg == ST_SCAN) && (scan_idx_reg == IDX_W'(NUM_CAND - 1));

   // One saturating counter per candidate
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CAND; gi++) begin : g_cand
         logic [CNT_W-1:0] cnt_reg;
         logic             inc;

         assign inc          = record && (code_reg == CODE_W'(gi + 1));
         assign cand_sat[gi] = inc && (cnt_reg == '1);
         assign tally_flat[gi*CNT_W +: CNT_W] = cnt_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               cnt_reg <= '0;
            end else if (inc && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
      end
   endgenerate

   // Winner scan step: pick the tally under scan_idx and fold it into the
   // running maximum. A strictly greater tally takes over and clears the tie;
   // an equal non-zero tally only marks the tie, so the lowest code keeps it.
   always_comb begin
      scan_val = '0;
      for (int k = 0; k < NUM_CAND; k++) begin
         if (scan_idx_reg == IDX_W'(k)) begin
            scan_val = tally_flat[k*CNT_W +: CNT_W];
         end
      end
      max_next  = max_reg;
      best_next = best_reg;
      tie_next  = tie_run_reg;
      if (scan_val > max_reg) begin
         max_next  = scan_val;
         best_next = scan_idx_reg + IDX_W'(1);
         tie_next  = 1'b0;
      end else if ((scan_val == max_reg) && (scan_val != '0)) begin
         tie_next  = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_OPEN: begin
            if (finish)          state_next = ST_SCAN;
            else if (digit_load) state_next = ST_ENTERED;
         end
         ST_ENTERED: begin
            if (finish)          state_next = ST_SCAN;
            else if (swap)       state_next = ST_OPEN;
            else if (valid_rise) state_next = ST_OPEN;
         end
         ST_SCAN: begin
            if (last_scan)       state_next = ST_DONE;
         end
         ST_DONE:                state_next = ST_DONE;
         default:                state_next = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_OPEN;
         code_reg        <= '0;
         valid_q_reg     <= 1'b0;
         vote_status_reg <= 1'b0;
         null_reg        <= '0;
         total_reg       <= '0;
         overflow_reg    <= 1'b0;
         scan_idx_reg    <= '0;
         max_reg         <= '0;
         best_reg        <= '0;
         tie_run_reg     <= 1'b0;
         winner_reg      <= '0;
         tie_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         // Tracked in every state so a valid held high across closing never fires
         valid_q_reg     <= valid;
         vote_status_reg <= record;

         if (record) begin
            total_reg <= total_reg + (CNT_W+IDX_W)'(1);
         end
         if (null_inc && (null_reg != '1)) begin
            null_reg <= null_reg + CNT_W'(1);
         end
         if (null_sat || (|cand_sat)) begin
            overflow_reg <= 1'b1;
         end

         case (state_reg)
            ST_OPEN: begin
               if (finish)          code_reg <= '0;
               else if (digit_load) code_reg <= digit;
            end
            ST_ENTERED: begin
               if (finish || swap || valid_rise) code_reg <= '0;
               else if (digit_load)              code_reg <= digit;
            end
            default:                code_reg <= '0;
         endcase

         if (state_reg == ST_SCAN) begin
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
            max_reg      <= max_next;
            best_reg     <= best_next;
            tie_run_reg  <= tie_next;
            if (last_scan) begin
               winner_reg <= best_next;
               tie_reg    <= tie_next;
            end
         end else if (state_reg != ST_DONE) begin
            // Keep the scan accumulators primed while voting is open
            scan_idx_reg <= '0;
            max_reg      <= '0;
            best_reg     <= '0;
            tie_run_reg  <= 1'b0;
         end
      end
   end

   assign vote_status   = vote_status_reg;
   assign tally         = tally_flat;
   assign null_count    = null_reg;
   assign total_votes   = total_reg;
   assign overflow      = overflow_reg;
   assign closed        = (state_reg == ST_SCAN) || (state_reg == ST_DONE);
   assign results_valid = (state_reg == ST_DONE);
   assign winner        = winner_reg;
   assign tie           = tie_reg;

endmodule

// File: tb/tb_urna_multi.sv
// -----------------------------------------------------------------------------
// tb_urna_multi -- self-checking bench for urna_multi.
// A main instance (CNT_W=8) and a narrow instance (CNT_W=2) share all inputs.
// A behavioural ballot-box model follows every clock edge of the main instance.
// -----------------------------------------------------------------------------
module tb_urna_multi;

   localparam int NC   = 4;
   localparam int CW   = 4;
   localparam int CNTW = 8;
   localparam int IW   = 4;
   localparam int TW   = CNTW + IW;
   localparam int MAXV = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CW-1:0]   digit = '0;
   logic            digit_load = 1'b0;
   logic            swap = 1'b0;
   logic            valid = 1'b0;
   logic            finish = 1'b0;

   logic            vote_status;
   logic [NC*CNTW-1:0] tally;
   logic [CNTW-1:0] null_count;
   logic [TW-1:0]   total_votes;
   logic            overflow, closed, results_valid, tie;
   logic [IW-1:0]   winner;

   logic            s_vote_status;
   logic [NC*2-1:0] s_tally;
   logic [1:0]      s_null_count;
   logic [2+IW-1:0] s_total_votes;
   logic            s_overflow, s_closed, s_results_valid, s_tie;
   logic [IW-1:0]   s_winner;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   urna_multi #(.NUM_CAND(NC), .CODE_W(CW), .CNT_W(CNTW), .IDX_W(IW)) u_dut (
      .clk(clk), .rst_n(rst_n), .digit(digit), .digit_load(digit_load),
      .swap(swap), .valid(valid), .finish(finish),
      .vote_status(vote_status), .tally(tally), .null_count(null_count),
      .total_votes(total_votes), .overflow(overflow), .closed(closed),
      .results_valid(results_valid), .winner(winner), .tie(tie)
   );

   urna_multi #(.NUM_CAND(NC), .CODE_W(CW), .CNT_W(2), .IDX_W(IW)) u_dut_small (
      .clk(clk), .rst_n(rst_n), .digit(digit), .digit_load(digit_load),
      .swap(swap), .valid(valid), .finish(finish),
      .vote_status(s_vote_status), .tally(s_tally), .null_count(s_null_count),
      .total_votes(s_total_votes), .overflow(s_overflow), .closed(s_closed),
      .results_valid(s_results_valid), .winner(s_winner), .tie(s_tie)
   );

   // ---------------- behavioural model ----------------
   int m_tally [NC];     // m_tally[k] counts votes for code k+1
   int m_null, m_total, m_code, m_scan_left, m_winner;
   bit m_ovf, m_has_code, m_prev_valid, m_closed, m_done, m_tie, m_vs;

   task automatic model_clear();
      for (int k = 0; k < NC; k++) m_tally[k] = 0;
      m_null = 0; m_total = 0; m_code = 0; m_scan_left = 0; m_winner = 0;
      m_ovf = 0; m_has_code = 0; m_prev_valid = 0; m_closed = 0;
      m_done = 0; m_tie = 0; m_vs = 0;
   endtask

   task automatic model_record(input int code);
      if (code >= 1 && code <= NC) begin
         if (m_tally[code-1] == MAXV) m_ovf = 1; else m_tally[code-1]++;
      end else begin
         if (m_null == MAXV) m_ovf = 1; else m_null++;
      end
      m_total++;
   endtask

   // Winner = lowest code holding the maximum tally; tie if several hold it
   task automatic model_results();
      int mx = 0;
      int n_at = 0;
      m_winner = 0;
      for (int k = 0; k < NC; k++) if (m_tally[k] > mx) mx = m_tally[k];
      if (mx > 0) begin
         for (int k = 0; k < NC; k++) begin
            if (m_tally[k] == mx) begin
               n_at++;
               if (m_winner == 0) m_winner = k + 1;
            end
         end
      end
      m_tie = (n_at > 1);
   endtask

   // Advance model with the current inputs, then one clock edge, sample at +1
   task automatic tick();
      bit rise;
      rise = valid && !m_prev_valid;
      m_vs = 0;
      if (!rst_n) begin
         model_clear();
      end else begin
         if (m_done) begin
         end else if (m_closed) begin
            m_scan_left--;
            if (m_scan_left == 0) begin
               m_done = 1;
               model_results();
            end
         end else if (finish) begin
            m_closed = 1; m_scan_left = NC; m_has_code = 0; m_code = 0;
         end else if (m_has_code) begin
            if (swap) begin
               m_has_code = 0; m_code = 0;
            end else if (rise) begin
               model_record(m_code);
               m_vs = 1; m_has_code = 0; m_code = 0;
            end else if (digit_load) begin
               m_code = int'(digit);
            end
         end else if (digit_load) begin
            m_has_code = 1; m_code = int'(digit);
         end
         m_prev_valid = valid;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; digit = '0; digit_load = 0; swap = 0; valid = 0; finish = 0;
      tick(); tick();
      rst_n = 1;
   endtask

   // Stimulus only: key a code and raise valid; caller drops valid later
   task automatic key_and_confirm(input int code);
      digit = CW'(code); digit_load = 1; tick();
      digit_load = 0; valid = 1; tick();
      $display("vote code=%0d vote_status=%0b total=%0d", code, vote_status, total_votes);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      key_and_confirm(2);
      valid = 0; tick();
      do_reset();
      vectors++; if (tally !== '0) begin $display("FAIL reset_tally: got %h want 0", tally); miscompares++; end
      vectors++; if (null_count !== '0) begin $display("FAIL reset_null: got %0d want 0", null_count); miscompares++; end
      vectors++; if (total_votes !== '0) begin $display("FAIL reset_total: got %0d want 0", total_votes); miscompares++; end
      vectors++; if (vote_status !== 1'b0) begin $display("FAIL reset_vs: got %0b want 0", vote_status); miscompares++; end
      vectors++; if ({overflow, closed, results_valid, tie} !== 4'b0) begin
         $display("FAIL reset_flags: got %b want 0000", {overflow, closed, results_valid, tie}); miscompares++; end
      vectors++; if (winner !== '0) begin $display("FAIL reset_winner: got %0d want 0", winner); miscompares++; end
   endtask

   task automatic test_basic();
      int codes[3] = '{3, 3, 4};
      do_reset();
      foreach (codes[i]) begin
         key_and_confirm(codes[i]);
         vectors++; if (vote_status !== 1'b1) begin $display("FAIL basic_pulse_hi: got %0b want 1", vote_status); miscompares++; end
         valid = 0; tick();
         vectors++; if (vote_status !== 1'b0) begin $display("FAIL basic_pulse_lo: got %0b want 0", vote_status); miscompares++; end
      end
      vectors++; if (tally[2*CNTW +: CNTW] !== CNTW'(2)) begin $display("FAIL basic_tally3: got %0d want 2", tally[2*CNTW +: CNTW]); miscompares++; end
      vectors++; if (tally[3*CNTW +: CNTW] !== CNTW'(1)) begin $display("FAIL basic_tally4: got %0d want 1", tally[3*CNTW +: CNTW]); miscompares++; end
      vectors++; if (total_votes !== TW'(3)) begin $display("FAIL basic_total: got %0d want 3", total_votes); miscompares++; end
   endtask

   task automatic test_valid_held();
      do_reset();
      key_and_confirm(1);
      digit = CW'(2); digit_load = 1; tick();
      digit_load = 0; tick(); tick();
      vectors++; if (total_votes !== TW'(1)) begin $display("FAIL held_total: got %0d want 1", total_votes); miscompares++; end
      vectors++; if (vote_status !== 1'b0) begin $display("FAIL held_vs: got %0b want 0", vote_status); miscompares++; end
      valid = 0; tick();
      valid = 1; tick();
      vectors++; if (vote_status !== 1'b1) begin $display("FAIL held_rearm_vs: got %0b want 1", vote_status); miscompares++; end
      vectors++; if (tally[1*CNTW +: CNTW] !== CNTW'(1)) begin $display("FAIL held_tally2: got %0d want 1", tally[1*CNTW +: CNTW]); miscompares++; end
      vectors++; if (total_votes !== TW'(2)) begin $display("FAIL held_total2: got %0d want 2", total_votes); miscompares++; end
      valid = 0; tick();
   endtask

   task automatic test_swap_null();
      do_reset();
      digit = CW'(2); digit_load = 1; tick();
      digit_load = 0; swap = 1; tick();
      swap = 0; digit = CW'(0); digit_load = 1; tick();
      digit_load = 0; valid = 1; tick();
      vectors++; if (null_count !== CNTW'(1)) begin $display("FAIL swap_null1: got %0d want 1", null_count); miscompares++; end
      vectors++; if (tally[1*CNTW +: CNTW] !== '0) begin $display("FAIL swap_tally2: got %0d want 0", tally[1*CNTW +: CNTW]); miscompares++; end
      valid = 0; tick();
      key_and_confirm(6);
      valid = 0; tick();
      vectors++; if (null_count !== CNTW'(2)) begin $display("FAIL swap_null2: got %0d want 2", null_count); miscompares++; end
      // swap and a confirm in the same cycle: swap wins, no vote
      digit = CW'(3); digit_load = 1; tick();
      digit_load = 0; swap = 1; valid = 1; tick();
      vectors++; if (vote_status !== 1'b0) begin $display("FAIL swap_beats_valid_vs: got %0b want 0", vote_status); miscompares++; end
      vectors++; if (total_votes !== TW'(2)) begin $display("FAIL swap_beats_valid_total: got %0d want 2", total_votes); miscompares++; end
      swap = 0; valid = 0; tick();
   endtask

   task automatic test_overflow();
      do_reset();
      repeat (5) begin
         key_and_confirm(1);
         valid = 0; tick();
      end
      vectors++; if (s_tally[1:0] !== 2'd3) begin $display("FAIL ovf_tally: got %0d want 3", s_tally[1:0]); miscompares++; end
      vectors++; if (s_overflow !== 1'b1) begin $display("FAIL ovf_flag: got %0b want 1", s_overflow); miscompares++; end
      vectors++; if (s_total_votes !== 6'd5) begin $display("FAIL ovf_total: got %0d want 5", s_total_votes); miscompares++; end
      vectors++; if (overflow !== 1'b0) begin $display("FAIL ovf_wide_flag: got %0b want 0", overflow); miscompares++; end
      vectors++; if (tally[0 +: CNTW] !== CNTW'(5)) begin $display("FAIL ovf_wide_tally: got %0d want 5", tally[0 +: CNTW]); miscompares++; end
   endtask

   task automatic test_winner();
      int sc_len[3]   = '{5, 3, 0};
      int sc_v[3][5]  = '{'{1, 1, 2, 2, 3}, '{2, 2, 1, 0, 0}, '{0, 0, 0, 0, 0}};
      int exp_win[3]  = '{1, 2, 0};
      int exp_tie[3]  = '{1, 0, 0};
      int n;
      for (int s = 0; s < 3; s++) begin
         do_reset();
         for (int j = 0; j < sc_len[s]; j++) begin
            key_and_confirm(sc_v[s][j]);
            valid = 0; tick();
         end
         finish = 1;
         n = 0;
         do begin
            tick();
            n++;
            if (n == 1) begin
               vectors++; if (closed !== 1'b1) begin $display("FAIL win%0d_closed: got %0b want 1", s, closed); miscompares++; end
               vectors++; if (winner !== '0) begin $display("FAIL win%0d_early: got %0d want 0", s, winner); miscompares++; end
            end
         end while (!results_valid && n < 20);
         $display("scenario %0d done after %0d cycles winner=%0d tie=%0b", s, n, winner, tie);
         vectors++; if (n != NC + 1) begin $display("FAIL win%0d_latency: got %0d want %0d", s, n, NC + 1); miscompares++; end
         vectors++; if (winner !== IW'(exp_win[s])) begin $display("FAIL win%0d_winner: got %0d want %0d", s, winner, exp_win[s]); miscompares++; end
         vectors++; if (tie !== exp_tie[s][0]) begin $display("FAIL win%0d_tie: got %0b want %0d", s, tie, exp_tie[s]); miscompares++; end
         // DONE ignores finish release and further votes
         finish = 0; digit = CW'(1); digit_load = 1; tick();
         digit_load = 0; valid = 1; tick();
         valid = 0; tick();
         vectors++; if (results_valid !== 1'b1) begin $display("FAIL win%0d_frozen_rv: got %0b want 1", s, results_valid); miscompares++; end
         vectors++; if (total_votes !== TW'(sc_len[s])) begin $display("FAIL win%0d_frozen_total: got %0d want %0d", s, total_votes, sc_len[s]); miscompares++; end
      end
   endtask

   task automatic test_finish_priority();
      do_reset();
      digit = CW'(3); digit_load = 1; tick();
      digit_load = 0; finish = 1; valid = 1; tick();
      vectors++; if (vote_status !== 1'b0) begin $display("FAIL fin_vs: got %0b want 0", vote_status); miscompares++; end
      vectors++; if (total_votes !== '0) begin $display("FAIL fin_total: got %0d want 0", total_votes); miscompares++; end
      vectors++; if (closed !== 1'b1) begin $display("FAIL fin_closed: got %0b want 1", closed); miscompares++; end
      tick();
      rst_n = 0; finish = 0; valid = 0; tick();
      vectors++; if (closed !== 1'b0) begin $display("FAIL midscan_rst_closed: got %0b want 0", closed); miscompares++; end
      vectors++; if (results_valid !== 1'b0) begin $display("FAIL midscan_rst_rv: got %0b want 0", results_valid); miscompares++; end
      rst_n = 1;
      key_and_confirm(2);
      vectors++; if (vote_status !== 1'b1) begin $display("FAIL midscan_reopen_vs: got %0b want 1", vote_status); miscompares++; end
      vectors++; if (total_votes !== TW'(1)) begin $display("FAIL midscan_reopen_total: got %0d want 1", total_votes); miscompares++; end
      valid = 0; tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 249) != 0);
         if (m_done && $urandom_range(0, 3) == 0) rst_n = 0;
         digit      = CW'($urandom_range(0, (1 << CW) - 1));
         digit_load = ($urandom_range(0, 2) == 0);
         swap       = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1) == 1) valid = ~valid;
         finish     = ($urandom_range(0, 59) == 0);
         tick();
         vectors++; if (vote_status !== m_vs) begin $display("FAIL rnd%0d_vs: got %0b want %0b", i, vote_status, m_vs); miscompares++; end
         for (int k = 0; k < NC; k++) begin
            vectors++; if (tally[k*CNTW +: CNTW] !== CNTW'(m_tally[k])) begin
               $display("FAIL rnd%0d_tally%0d: got %0d want %0d", i, k + 1, tally[k*CNTW +: CNTW], m_tally[k]); miscompares++; end
         end
         vectors++; if (null_count !== CNTW'(m_null)) begin $display("FAIL rnd%0d_null: got %0d want %0d", i, null_count, m_null); miscompares++; end
         vectors++; if (total_votes !== TW'(m_total)) begin $display("FAIL rnd%0d_total: got %0d want %0d", i, total_votes, m_total); miscompares++; end
         vectors++; if (overflow !== m_ovf) begin $display("FAIL rnd%0d_ovf: got %0b want %0b", i, overflow, m_ovf); miscompares++; end
         vectors++; if (closed !== m_closed) begin $display("FAIL rnd%0d_closed: got %0b want %0b", i, closed, m_closed); miscompares++; end
         vectors++; if (results_valid !== m_done) begin $display("FAIL rnd%0d_rv: got %0b want %0b", i, results_valid, m_done); miscompares++; end
         vectors++; if (winner !== IW'(m_done ? m_winner : 0)) begin $display("FAIL rnd%0d_winner: got %0d want %0d", i, winner, m_done ? m_winner : 0); miscompares++; end
         vectors++; if (tie !== (m_done & m_tie)) begin $display("FAIL rnd%0d_tie: got %0b want %0b", i, tie, m_done & m_tie); miscompares++; end
      end
      rst_n = 1; digit_load = 0; swap = 0; valid = 0; finish = 0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_valid_held();
      test_swap_null();
      test_overflow();
      test_winner();
      test_finish_priority();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
